// File: rtl/fft_pkg.sv
// Shared types and helpers for the 8-point FFT/IFFT cores.
//   cplx16_t : one complex sample, 16-bit two's-complement re/im
//   frame_t  : eight samples, index k = X[k] / x[k]
//   frame_unpack / frame_pack_re / frame_pack_im : convert between a frame and
//     the flat 128-bit lane buses (lane k = bits [16k+15:16k]).
//   ext17, tw_mul, swap_ri, jrot_plus, jrot_minus : datapath helpers.
package fft_pkg;

    localparam int N_POINTS      = 8;
    localparam int TW_Q8_DEFAULT = 181;
    localparam int LANE_W        = 16;
    localparam int FRAME_W       = N_POINTS * LANE_W;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
    } cplx16_t;

    typedef cplx16_t [N_POINTS-1:0] frame_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S1,
        ST_S2,
        ST_TW,
        ST_S3,
        ST_OUT
    } state_t;

    function automatic frame_t frame_unpack(input logic [FRAME_W-1:0] re,
                                            input logic [FRAME_W-1:0] im);
        frame_t f;
        for (int k = 0; k < N_POINTS; k++) begin
            f[k].re = re[LANE_W*k +: LANE_W];
            f[k].im = im[LANE_W*k +: LANE_W];
        end
        return f;
    endfunction

    function automatic logic [FRAME_W-1:0] frame_pack_re(input frame_t f);
        logic [FRAME_W-1:0] v;
        for (int k = 0; k < N_POINTS; k++) v[LANE_W*k +: LANE_W] = f[k].re;
        return v;
    endfunction

    function automatic logic [FRAME_W-1:0] frame_pack_im(input frame_t f);
        logic [FRAME_W-1:0] v;
        for (int k = 0; k < N_POINTS; k++) v[LANE_W*k +: LANE_W] = f[k].im;
        return v;
    endfunction

    function automatic logic signed [16:0] ext17(input logic [15:0] v);
        return $signed({v[15], v});
    endfunction

    // x * c / 256 with floor; x is an exact 17-bit sum/difference. Negation is
    // applied to the wide product so -(-65536) cannot overflow.
    function automatic logic [15:0] tw_mul(input logic signed [16:0] x,
                                           input logic [7:0]         c,
                                           input logic               neg);
        logic signed [25:0] p;
        p = $signed({{9{x[16]}}, x}) * $signed({18'd0, c});
        if (neg) p = -p;
        return 16'(p >>> 8);
    endfunction

    // Feeding (b.im, b.re) into a plain butterfly lets a +/-j*b rotation be
    // rebuilt from its sum and difference outputs without negating anything
    // at 16 bits:  a + j*b = (dif.re, sum.im),  a - j*b = (sum.re, dif.im).
    function automatic cplx16_t swap_ri(input cplx16_t c);
        cplx16_t r;
        r.re = c.im;
        r.im = c.re;
        return r;
    endfunction

    function automatic cplx16_t jrot_plus(input cplx16_t s, input cplx16_t d);
        cplx16_t r;
        r.re = d.re;
        r.im = s.im;
        return r;
    endfunction

    function automatic cplx16_t jrot_minus(input cplx16_t s, input cplx16_t d);
        cplx16_t r;
        r.re = s.re;
        r.im = d.im;
        return r;
    endfunction

endpackage

// File: rtl/ifft8_core_if.sv
// Frame handshake bundle of ifft8_core.
//   in_valid/in_ready + in_real/in_imag    : spectrum frame in
//   out_valid/out_ready + out_real/out_imag : time-domain frame out
// slave = the core's view, master = the source/sink's view.
interface ifft8_core_if;

    logic                        in_valid;
    logic                        in_ready;
    logic [fft_pkg::FRAME_W-1:0] in_real;
    logic [fft_pkg::FRAME_W-1:0] in_imag;
    logic                        out_valid;
    logic                        out_ready;
    logic [fft_pkg::FRAME_W-1:0] out_real;
    logic [fft_pkg::FRAME_W-1:0] out_imag;

    modport slave (
        input  in_valid, in_real, in_imag, out_ready,
        output in_ready, out_valid, out_real, out_imag
    );

    modport master (
        output in_valid, in_real, in_imag, out_ready,
        input  in_ready, out_valid, out_real, out_imag
    );

endinterface

// File: rtl/cbfly16.sv
// Combinational complex butterfly: sum_o = a_i + b_i, dif_o = a_i - b_i.
// Each part is formed at 17 bits, optionally shifted right by one
// (arithmetic, floor) and truncated to 16 bits.
//   a_i, b_i      : operands
//   sum_o, dif_o  : results
module cbfly16
    import fft_pkg::*;
#(
    parameter bit SCALE_EN = 1'b1
) (
    input  cplx16_t a_i,
    input  cplx16_t b_i,
    output cplx16_t sum_o,
    output cplx16_t dif_o
);

    function automatic logic [15:0] addsub(input logic [15:0] x,
                                           input logic [15:0] y,
                                           input logic        sub);
        logic signed [16:0] r;
        r = sub ? (ext17(x) - ext17(y)) : (ext17(x) + ext17(y));
        return 16'(SCALE_EN ? (r >>> 1) : r);
    endfunction

    assign sum_o.re = addsub(a_i.re, b_i.re, 1'b0);
    assign sum_o.im = addsub(a_i.im, b_i.im, 1'b0);
    assign dif_o.re = addsub(a_i.re, b_i.re, 1'b1);
    assign dif_o.im = addsub(a_i.im, b_i.im, 1'b1);

endmodule

// File: rtl/ifft8_core.sv
// 8-point radix-2 DIT inverse FFT, one frame at a time.
// IDLE -> S1 -> S2 -> TW -> S3 -> OUT; one working frame register is
// rewritten in place by each stage, the result is held in its own register.
//   CLK, RST_N : clock, synchronous active-low reset
//   io         : frame handshake bundle (slave side)
module ifft8_core
    import fft_pkg::*;
#(
    parameter int TW_Q8    = TW_Q8_DEFAULT,
    parameter bit SCALE_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    ifft8_core_if.slave io
);

    localparam logic [7:0] TW_C = 8'(TW_Q8);

    state_t  state_q;
    frame_t  work_q;
    frame_t  out_q;
    logic    out_valid_q;

    cplx16_t bf_a [4];
    cplx16_t bf_b [4];
    cplx16_t bf_s [4];
    cplx16_t bf_d [4];
    cplx16_t t5;
    cplx16_t t7;

    assign io.in_ready  = (state_q == ST_IDLE);
    assign io.out_valid = out_valid_q;
    assign io.out_real  = frame_pack_re(out_q);
    assign io.out_imag  = frame_pack_im(out_q);

    // Four butterflies shared by the three add stages; operands are routed
    // per stage.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        bf_a[0] = work_q[0];  bf_b[0] = work_q[4];
        bf_a[1] = work_q[2];  bf_b[1] = work_q[6];
        bf_a[2] = work_q[1];  bf_b[2] = work_q[5];
        bf_a[3] = work_q[3];  bf_b[3] = work_q[7];
        case (state_q)
            ST_S2: begin
                bf_a[0] = work_q[0];  bf_b[0] = work_q[2];
                bf_a[1] = work_q[1];  bf_b[1] = swap_ri(work_q[3]);
                bf_a[2] = work_q[4];  bf_b[2] = work_q[6];
                bf_a[3] = work_q[5];  bf_b[3] = swap_ri(work_q[7]);
            end
            ST_S3: begin
                bf_a[0] = work_q[0];  bf_b[0] = work_q[4];
                bf_a[1] = work_q[1];  bf_b[1] = work_q[5];
                bf_a[2] = work_q[2];  bf_b[2] = swap_ri(work_q[6]);
                bf_a[3] = work_q[3];  bf_b[3] = work_q[7];
            end
            default: ;
        endcase
    end

    for (genvar b = 0; b < 4; b++) begin : g_bfly
        cbfly16 #(.SCALE_EN(SCALE_EN)) u_bfly (
            .a_i   (bf_a[b]),
            .b_i   (bf_b[b]),
            .sum_o (bf_s[b]),
            .dif_o (bf_d[b])
        );
    end

    // t5 = h5 * W8^-1, t7 = h7 * W8^-3
    assign t5.re = tw_mul(ext17(work_q[5].re) - ext17(work_q[5].im), TW_C, 1'b0);
    assign t5.im = tw_mul(ext17(work_q[5].re) + ext17(work_q[5].im), TW_C, 1'b0);
    assign t7.re = tw_mul(ext17(work_q[7].re) + ext17(work_q[7].im), TW_C, 1'b1);
    assign t7.im = tw_mul(ext17(work_q[7].re) - ext17(work_q[7].im), TW_C, 1'b0);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            // NOTE: the stage registers are reset too, so an abandoned frame
            // leaves no trace in the datapath.
            state_q     <= ST_IDLE;
            work_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (io.in_valid) begin
                        work_q  <= frame_unpack(io.in_real, io.in_imag);
                        state_q <= ST_S1;
                    end
                end
                ST_S1: begin
                    work_q[0] <= bf_s[0];  work_q[1] <= bf_d[0];
                    work_q[2] <= bf_s[1];  work_q[3] <= bf_d[1];
                    work_q[4] <= bf_s[2];  work_q[5] <= bf_d[2];
                    work_q[6] <= bf_s[3];  work_q[7] <= bf_d[3];
                    state_q   <= ST_S2;
                end
                ST_S2: begin
                    work_q[0] <= bf_s[0];
                    work_q[2] <= bf_d[0];
                    work_q[1] <= jrot_plus(bf_s[1], bf_d[1]);
                    work_q[3] <= jrot_minus(bf_s[1], bf_d[1]);
                    work_q[4] <= bf_s[2];
                    work_q[6] <= bf_d[2];
                    work_q[5] <= jrot_plus(bf_s[3], bf_d[3]);
                    work_q[7] <= jrot_minus(bf_s[3], bf_d[3]);
                    state_q   <= ST_TW;
                end
                ST_TW: begin
                    work_q[5] <= t5;
                    work_q[7] <= t7;
                    state_q   <= ST_S3;
                end
                ST_S3: begin
                    out_q[0]    <= bf_s[0];
                    out_q[4]    <= bf_d[0];
                    out_q[1]    <= bf_s[1];
                    out_q[5]    <= bf_d[1];
                    out_q[2]    <= jrot_plus(bf_s[2], bf_d[2]);
                    out_q[6]    <= jrot_minus(bf_s[2], bf_d[2]);
                    out_q[3]    <= bf_s[3];
                    out_q[7]    <= bf_d[3];
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifft8_core.sv
// Self-checking bench for ifft8_core: directed frames with known results,
// backpressure, mid-frame reset, random frames against a bit-true generic
// radix-2 model, and a forward-DFT loopback with a tolerance.
module tb_ifft8_core;
    import fft_pkg::*;

    typedef int vec8_t [8];

    localparam int    TWQ = 181;
    localparam real   PI  = 3.14159265358979;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ifft8_core_if bus ();

    ifft8_core #(.TW_Q8(TWQ), .SCALE_EN(1'b1)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .io    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic [31:0] lane(input logic [127:0] v, input int k);
        logic [15:0] s;
        s = v[16*k +: 16];
        return {{16{s[15]}}, s};
    endfunction

    function automatic int w16(input int v);
        shortint s;
        s = shortint'(v);
        return int'(s);
    endfunction

    // Generic in-place radix-2 DIT inverse FFT with 1/2 per stage; twiddle
    // W8^-e applied exactly for e=0,2 and with the Q0.8 constant for e=1,3.
    task automatic ref_ifft(input vec8_t xr, input vec8_t xi,
                            output vec8_t yr, output vec8_t yi);
        int br, bi, tr, ti, ar, ai, p, q, e, rv;
        for (int n = 0; n < 8; n++) begin
            rv = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
            yr[n] = xr[rv];
            yi[n] = xi[rv];
        end
        for (int l = 1; l < 8; l = l * 2) begin
            for (int base = 0; base < 8; base += 2 * l) begin
                for (int k = 0; k < l; k++) begin
                    p = base + k;
                    q = p + l;
                    br = yr[q];
                    bi = yi[q];
                    e = k * 4 / l;
                    case (e)
                        0: begin tr = br; ti = bi; end
                        1: begin tr = w16(((br - bi) * TWQ) >>> 8); ti = w16(((br + bi) * TWQ) >>> 8); end
                        2: begin tr = -bi; ti = br; end
                        default: begin tr = w16((-(br + bi) * TWQ) >>> 8); ti = w16(((br - bi) * TWQ) >>> 8); end
                    endcase
                    ar = yr[p];
                    ai = yi[p];
                    yr[p] = w16((ar + tr) >>> 1);
                    yi[p] = w16((ai + ti) >>> 1);
                    yr[q] = w16((ar - tr) >>> 1);
                    yi[q] = w16((ai - ti) >>> 1);
                end
            end
        end
    endtask

    function automatic int rnd(input real v);
        return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
    endfunction

    // Unscaled forward DFT, rounded to integers.
    task automatic fwd_dft(input vec8_t xr, input vec8_t xi,
                           output vec8_t fr, output vec8_t fi);
        real sr, si, a;
        for (int k = 0; k < 8; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < 8; n++) begin
                a = 2.0 * PI * real'(n * k) / 8.0;
                sr = sr + real'(xr[n]) * $cos(a) + real'(xi[n]) * $sin(a);
                si = si + real'(xi[n]) * $cos(a) - real'(xr[n]) * $sin(a);
            end
            fr[k] = rnd(sr);
            fi[k] = rnd(si);
        end
    endtask

    // Called at a negedge; returns at the negedge after the capture edge.
    task automatic send_frame(input vec8_t xr, input vec8_t xi);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.in_real[16*k +: 16] = 16'(xr[k]);
            bus.in_imag[16*k +: 16] = 16'(xi[k]);
        end
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", 32'(guard < 50), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Negedges after the capture edge until out_valid is seen (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic check_frame(input string tag, input vec8_t er, input vec8_t ei);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_re%0d", tag, k), lane(bus.out_real, k), 32'(er[k]));
            check($sformatf("%s_im%0d", tag, k), lane(bus.out_imag, k), 32'(ei[k]));
        end
    endtask

    initial begin
        vec8_t xr, xi, er, ei, fr, fi;
        int    lat;
        bit    seen;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_real   = '0;
        bus.in_imag   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_real", 32'(|bus.out_real), 32'd0);
        check("rst_out_imag", 32'(|bus.out_imag), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Impulse: all outputs 100
        xr = '{800, 0, 0, 0, 0, 0, 0, 0};
        xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(xr, xi);
        check("impulse_early_valid", 32'(bus.out_valid), 32'd0);
        wait_out(lat);
        check("impulse_latency", 32'(lat), 32'd4);
        er = '{100, 100, 100, 100, 100, 100, 100, 100};
        ei = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_frame("impulse", er, ei);
        release_out();
        check("hs_out_valid_low", 32'(bus.out_valid), 32'd0);
        check("hs_in_ready_high", 32'(bus.in_ready), 32'd1);
        check("hs_out_kept", lane(bus.out_real, 0), 32'd100);

        // Constant spectrum: only x0 survives; left unaccepted for backpressure
        xr = '{800, 800, 800, 800, 800, 800, 800, 800};
        send_frame(xr, xi);
        wait_out(lat);
        check("const_latency", 32'(lat), 32'd4);
        er = '{800, 0, 0, 0, 0, 0, 0, 0};
        check_frame("const", er, ei);

        // Backpressure with a second frame pending on the input
        xr = '{0, 800, 0, 0, 0, 0, 0, 0};
        bus.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.in_real[16*k +: 16] = 16'(xr[k]);
            bus.in_imag[16*k +: 16] = 16'(xi[k]);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_x0", lane(bus.out_real, 0), 32'd800);
        end
        release_out();
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_captured", 32'(bus.in_ready), 32'd0);
        wait_out(lat);
        check("bin1_latency", 32'(lat), 32'd4);
        er = '{100, 70, 0, -71, -100, -71, 0, 71};
        ei = '{0, 70, 100, 70, 0, -71, -100, -71};
        check_frame("bin1", er, ei);
        release_out();

        // Reset while in TW
        xr = '{800, 0, 0, 0, 0, 0, 0, 0};
        xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(xr, xi);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_real", 32'(|bus.out_real), 32'd0);
        check("midrst_out_imag", 32'(|bus.out_imag), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        check("midrst_no_stale", 32'(seen), 32'd0);

        // Random full-range frames, bit-true against the model
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 8; k++) begin
                xr[k] = int'(shortint'($urandom));
                xi[k] = int'(shortint'($urandom));
            end
            ref_ifft(xr, xi, er, ei);
            send_frame(xr, xi);
            wait_out(lat);
            check("rand_latency", 32'(lat), 32'd4);
            check_frame($sformatf("rand%0d", f), er, ei);
            release_out();
        end

        // Loopback through a forward DFT
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 8; k++) begin
                xr[k] = int'($urandom_range(0, 4000)) - 2000;
                xi[k] = int'($urandom_range(0, 4000)) - 2000;
            end
            fwd_dft(xr, xi, fr, fi);
            ref_ifft(fr, fi, er, ei);
            send_frame(fr, fi);
            wait_out(lat);
            check("loop_latency", 32'(lat), 32'd4);
            check_frame($sformatf("loop%0d", f), er, ei);
            for (int k = 0; k < 8; k++) begin
                int dr, di;
                dr = int'($signed(lane(bus.out_real, k))) - xr[k];
                di = int'($signed(lane(bus.out_imag, k))) - xi[k];
                check($sformatf("loop%0d_tol%0d", f, k),
                      32'((dr <= 4) && (dr >= -4) && (di <= 4) && (di >= -4)), 32'd1);
            end
            release_out();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
